// File: rtl/lsu_hs.sv
// lsu_hs: load/store unit with a valid/ready request handshake.
// Serves a byte-addressed data memory with configurable read latency, NUM_OUT memory-mapped
// 32-bit output registers, and a read-only, two-stage-synchronised switch input.
// Ports:
//   i_clk, i_reset              clock (rising edge), asynchronous active-high reset
//   i_req_valid / o_req_ready   request handshake; a request is taken when both are high
//   i_we, i_size, i_unsigned    store/load, access size (byte/half/word), zero/sign extension
//   i_addr, i_st_data           byte address, right-aligned store data
//   o_rsp_valid                 one-cycle completion pulse
//   o_ld_data, o_misaligned     load result and alignment error, valid with o_rsp_valid
//   i_io_sw                     asynchronous switch inputs
//   o_io_out                    output registers, register k at bits [32k+31:32k]
module lsu_hs #(
  parameter int unsigned DMEM_AW = 11,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned NUM_OUT = 5
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_we,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_st_data,
  output logic                 o_rsp_valid,
  output logic [31:0]          o_ld_data,
  output logic                 o_misaligned,
  input  logic [31:0]          i_io_sw,
  output logic [NUM_OUT*32-1:0] o_io_out
);

  localparam int unsigned Words = 2 ** (DMEM_AW - 2);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q;
  logic          we_q, uns_q, mis_q;
  logic [1:0]    size_q, lane_q;
  logic [31:0]   sw_s1_q, sw_s2_q;
  logic [31:0]   io_q [NUM_OUT];
  logic [31:0]   mem_q [Words];

  logic          accept, is_io, is_sw, mis_in, st_ok;
  logic [2:0]    idx;
  logic [DMEM_AW-3:0] widx;
  logic [3:0]    be_in;
  logic [31:0]   wdata_in, rd_in, lane_word, ext;
  logic          unused_addr;

  assign unused_addr = ^i_addr;

  assign accept = i_req_valid && (state_q == StIdle);
  assign is_io  = i_addr[28];
  assign is_sw  = i_addr[28] && i_addr[16];
  assign idx    = i_addr[14:12];
  assign widx   = i_addr[DMEM_AW-1:2];

  // Request decode: alignment, lane enables and lane-replicated write data
  always_comb begin
    mis_in   = 1'b0;
    be_in    = 4'b0000;
    wdata_in = i_st_data;
    case (i_size)
      2'b00: begin
        be_in    = 4'b0001 << i_addr[1:0];
        wdata_in = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        mis_in   = i_addr[0];
        be_in    = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{i_st_data[15:0]}};
      end
      2'b10: begin
        mis_in = (i_addr[1:0] != 2'b00);
        be_in  = 4'b1111;
      end
      default: mis_in = 1'b1;
    endcase
  end

  assign st_ok = accept && i_we && !mis_in;

  // Read source selected at acceptance; unmapped output indices read as zero
  always_comb begin
    rd_in = '0;
    if (!is_io) begin
      rd_in = mem_q[widx];
    end else if (is_sw) begin
      rd_in = sw_s2_q;
    end else begin
      for (int k = 0; k < int'(NUM_OUT); k++) begin
        if (idx == 3'(k)) rd_in = io_q[k];
      end
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!i_we && !mis_in && !is_io && (MEM_LAT > 1)) begin
            state_d = StWait;
            cnt_d   = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 2'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      for (int k = 0; k < int'(NUM_OUT); k++) io_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_s1_q <= i_io_sw;
      sw_s2_q <= sw_s1_q;
      if (accept) begin
        rdata_q <= rd_in;
        we_q    <= i_we;
        uns_q   <= i_unsigned;
        mis_q   <= mis_in;
        size_q  <= i_size;
        lane_q  <= i_addr[1:0];
      end
      if (st_ok && is_io && !is_sw) begin
        for (int k = 0; k < int'(NUM_OUT); k++) begin
          if (idx == 3'(k)) begin
            for (int b = 0; b < 4; b++) begin
              if (be_in[b]) io_q[k][8*b +: 8] <= wdata_in[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Data memory has no reset; contents survive i_reset
  always_ff @(posedge i_clk) begin
    if (st_ok && !is_io) begin
      for (int b = 0; b < 4; b++) begin
        if (be_in[b]) mem_q[widx][8*b +: 8] <= wdata_in[8*b +: 8];
      end
    end
  end

  // Lane extraction and extension of the captured word
  always_comb begin
    lane_word = rdata_q >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   ext = uns_q ? {24'b0, lane_word[7:0]} : {{24{lane_word[7]}}, lane_word[7:0]};
      2'b01:   ext = uns_q ? {16'b0, lane_word[15:0]} : {{16{lane_word[15]}}, lane_word[15:0]};
      default: ext = rdata_q;
    endcase
  end

  always_comb begin
    o_req_ready  = (state_q == StIdle);
    o_rsp_valid  = (state_q == StResp);
    o_misaligned = o_rsp_valid && mis_q;
    o_ld_data    = '0;
    if (o_rsp_valid && !we_q && !mis_q) o_ld_data = ext;
  end

  for (genvar k = 0; k < int'(NUM_OUT); k++) begin : g_out
    assign o_io_out[32*k +: 32] = io_q[k];
  end

endmodule

// File: tb/tb_lsu_hs.sv
module tb_lsu_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  vld;
  logic        we, uns;
  logic [1:0]  size;
  logic [31:0] addr, st_data, io_sw;
  logic [2:0]  rdy, rsp, mis;
  logic [31:0] ld [3];
  logic [159:0] io [3];

  int tests = 0;
  int fails = 0;

  logic [31:0] r_ld;
  logic        r_mis;
  int          r_k, r_low, r_pulses;

  always #5 clk = ~clk;

  lsu_hs #(.DMEM_AW(11), .MEM_LAT(1), .NUM_OUT(5)) u_lat1 (
    .i_clk(clk), .i_reset(reset), .i_req_valid(vld[0]), .o_req_ready(rdy[0]), .i_we(we),
    .i_size(size), .i_unsigned(uns), .i_addr(addr), .i_st_data(st_data),
    .o_rsp_valid(rsp[0]), .o_ld_data(ld[0]), .o_misaligned(mis[0]), .i_io_sw(io_sw),
    .o_io_out(io[0])
  );

  lsu_hs #(.DMEM_AW(11), .MEM_LAT(3), .NUM_OUT(5)) u_lat3 (
    .i_clk(clk), .i_reset(reset), .i_req_valid(vld[1]), .o_req_ready(rdy[1]), .i_we(we),
    .i_size(size), .i_unsigned(uns), .i_addr(addr), .i_st_data(st_data),
    .o_rsp_valid(rsp[1]), .o_ld_data(ld[1]), .o_misaligned(mis[1]), .i_io_sw(io_sw),
    .o_io_out(io[1])
  );

  lsu_hs #(.DMEM_AW(11), .MEM_LAT(4), .NUM_OUT(5)) u_lat4 (
    .i_clk(clk), .i_reset(reset), .i_req_valid(vld[2]), .o_req_ready(rdy[2]), .i_we(we),
    .i_size(size), .i_unsigned(uns), .i_addr(addr), .i_st_data(st_data),
    .o_rsp_valid(rsp[2]), .o_ld_data(ld[2]), .o_misaligned(mis[2]), .i_io_sw(io_sw),
    .o_io_out(io[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request to instance d and watch exp_lat+1 cycles after acceptance.
  // With hold set, i_req_valid stays high through the busy window.
  task automatic do_req(input int d, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                        input bit hold);
    int n;
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; st_data = wd; vld[d] = 1'b1;
    n = 0;
    while (!rdy[d] && n < 16) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (!hold) vld[d] = 1'b0;
    r_k = 0; r_low = 0; r_pulses = 0; r_ld = 'x; r_mis = 1'bx;
    for (int i = 1; i <= exp_lat + 1; i++) begin
      @(negedge clk);
      if (!rdy[d]) r_low++;
      if (rsp[d]) begin
        r_pulses++;
        if (r_k == 0) begin
          r_k = i; r_ld = ld[d]; r_mis = mis[d];
        end
      end
    end
    vld[d] = 1'b0;
  endtask

  initial begin
    int seen;
    reset = 1'b1; vld = 3'b000; we = 1'b0; size = 2'b10; uns = 1'b0;
    addr = '0; st_data = '0; io_sw = '0;
    #12;
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_rsp", 32'(rsp[0]), 32'd0);
    chk("rst_ld", ld[0], 32'h0);
    chk("rst_mis", 32'(mis[0]), 32'd0);
    chk("rst_io0", io[0][31:0], 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Word store into all three instances
    for (int d = 0; d < 3; d++) do_req(d, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, 1'b0);
    chk("sw_lat", 32'(r_k), 32'd1);
    chk("sw_ld_zero", r_ld, 32'h0);

    // Sub-word loads, single-cycle latency
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1, 1'b0);
    chk("lb_data", r_ld, 32'hFFFFFFDE);
    chk("lb_lat", 32'(r_k), 32'd1);
    chk("lb_ready_low", 32'(r_low), 32'd1);
    chk("lb_pulses", 32'(r_pulses), 32'd1);
    do_req(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, 1'b0);
    chk("lbu_data", r_ld, 32'h000000DE);
    do_req(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1, 1'b0);
    chk("lh_data", r_ld, 32'hFFFFDEAD);
    do_req(0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1, 1'b0);
    chk("lhu_data", r_ld, 32'h0000BEEF);
    do_req(0, 1'b0, 2'b00, 1'b1, 32'h811, 32'h0, 1, 1'b0);
    chk("alias_lbu", r_ld, 32'h000000BE);

    // MEM_LAT=3 word load with valid held through the busy window
    do_req(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 1'b1);
    chk("lat3_data", r_ld, 32'hDEADBEEF);
    chk("lat3_lat", 32'(r_k), 32'd3);
    chk("lat3_ready_low", 32'(r_low), 32'd3);
    chk("lat3_pulses", 32'(r_pulses), 32'd1);

    // Output registers
    do_req(0, 1'b1, 2'b00, 1'b0, 32'h1000_0001, 32'h000000A5, 1, 1'b0);
    chk("sb_io0", io[0][31:0], 32'h0000A500);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h1000_0000, 32'h0, 1, 1'b0);
    chk("lw_io0", r_ld, 32'h0000A500);
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h1000_7000, 32'h00000055, 1, 1'b0);
    for (int k = 0; k < 5; k++) chk($sformatf("unmapped_io%0d", k), io[0][32*k +: 32],
                                    (k == 0) ? 32'h0000A500 : 32'h0);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h1000_7000, 32'h0, 1, 1'b0);
    chk("unmapped_ld", r_ld, 32'h0);
    chk("unmapped_mis", 32'(r_mis), 32'd0);

    // Switch input
    io_sw = 32'h00000F0F;
    repeat (3) @(negedge clk);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0, 1, 1'b0);
    chk("sw_load", r_ld, 32'h00000F0F);
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'h12345678, 1, 1'b0);
    chk("sw_store_mis", 32'(r_mis), 32'd0);
    do_req(0, 1'b0, 2'b00, 1'b1, 32'h1001_0001, 32'h0, 1, 1'b0);
    chk("sw_lbu", r_ld, 32'h0000000F);

    // Misalignment
    do_req(0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1, 1'b0);
    chk("lh_mis_flag", 32'(r_mis), 32'd1);
    chk("lh_mis_ld", r_ld, 32'h0);
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h11223344, 1, 1'b0);
    chk("sw_mis_flag", 32'(r_mis), 32'd1);
    do_req(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h11223344, 1, 1'b0);
    chk("sz11_st_mis", 32'(r_mis), 32'd1);
    do_req(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 1'b0);
    chk("sz11_ld_mis", 32'(r_mis), 32'd1);
    chk("sz11_ld_zero", r_ld, 32'h0);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 1'b0);
    chk("mem_unchanged", r_ld, 32'hDEADBEEF);

    // Reset during WAIT on the MEM_LAT=4 instance
    @(negedge clk);
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h10; vld[2] = 1'b1;
    @(posedge clk);
    #1 vld[2] = 1'b0;
    @(negedge clk);
    chk("lat4_busy", 32'(rdy[2]), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(rdy[2]), 32'd1);
    chk("rst_mid_io0", io[0][31:0], 32'h0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp[2]) seen++;
    end
    chk("rst_no_late_rsp", 32'(seen), 32'd0);
    do_req(2, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 4, 1'b0);
    chk("lat4_data", r_ld, 32'hDEADBEEF);
    chk("lat4_lat", 32'(r_k), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
